fir_out_requant: RTL and testbench
==================================

Name: fir_out_requant

Overview:
- Sits directly downstream of the pipelined FIR. Consumes its 32-bit full-precision accumulator stream.
- Discards the start-up transient while the FIR delay line fills, then decimates by DECIM.
- Rounds and saturates each kept sample to OUT_W bits and buffers it in a small FIFO.
- Presents the FIFO to the consumer over a valid/ready interface.

Parameters:
- IN_W, 32, input sample width (signed)
- OUT_W, 16, output sample width (signed)
- SHIFT, 15, arithmetic right shift applied before saturation; must be ≥1
- DECIM, 4, decimation ratio; keep 1 of every DECIM post-warm-up samples; must be ≥1
- WARMUP, 326, number of accepted input samples discarded after reset (321 taps + 5 FIR pipeline cycles)
- DEPTH, 8, FIFO depth in entries; power of two, ≥2

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  in_data carries a FIR sample this cycle
- in_data  in  IN_W  signed FIR accumulator output
- clr_flags  in  1  synchronous clear of the sticky flags
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data this cycle
- out_data  out  OUT_W  signed FIFO head (first-word fall-through)
- fifo_level  out  $clog2(DEPTH)+1  current occupancy
- warm  out  1  warm-up complete
- sat_flag  out  1  sticky: at least one kept sample saturated
- ovf_flag  out  1  sticky: at least one kept sample dropped because the FIFO was full

Behaviour:
- Reset (async, active-high): all counters, FIFO pointers and flags go to 0. out_valid=0, out_data=0, fifo_level=0, warm=0. FIFO contents are discarded.
- Warm-up counter counts cycles with in_valid=1. The first WARMUP such samples are dropped.
- warm rises on the edge that accepts sample WARMUP and stays high until reset. With WARMUP=0, warm=1 from the first edge after reset.
- Decimation phase counter (0..DECIM-1) advances only on in_valid while warm=1. A sample is kept when phase==0, so the first post-warm-up sample is always kept. The counter wraps DECIM-1 -> 0. With DECIM=1, every sample is kept.
- Requant, computed in IN_W+1 bits:
  - r = (in_data + 2^(SHIFT-1)) >>> SHIFT (round half toward +inf).
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Result is registered in stage register q with q_valid. q_valid is high for exactly one cycle per kept sample.
- FIFO push happens when q_valid=1. Pop happens when out_valid && out_ready.
- Latency: a kept sample accepted at edge E is in q after E. It is written to the FIFO at E+1, and out_valid is high after E+1 if the FIFO was empty. There is no bypass path.
- Full with push and no pop: the sample is dropped, ovf_flag is set, and contents are unchanged.
- Full with push and pop in the same cycle: both happen; level stays DEPTH; no overflow.
- Empty with out_ready=1: no pop; out_data holds its last value.
- out_data is stable while out_valid=1 and out_ready=0.
- sat_flag is set in the cycle q captures a clipped value. ovf_flag is set on a drop. clr_flags clears both flags; if a set condition and clr_flags coincide, set wins.
- in_valid may be high every cycle; the block never back-pressures upstream.

Decomposition:
- Shared package fir_pkg holds:
  - FIR_IN_W=32, FIR_OUT_W=16, FIR_TAPS=321, FIR_PIPE_LAT=5.
  - A function computing WARMUP from taps + latency.
  - Saturation limit constants derived from OUT_W.
- Sub-module fir_out_fifo: a synchronous FWFT FIFO with push, pop, full, empty and level outputs. Top level holds the counters, requant and flags.

Test Plan (bench overrides WARMUP=3, DECIM=1 unless noted):
- Warm-up and rounding: feed 0x00000001, 0x00000002, 0x00000003, then 0x00004000, 0xFFFFC000, 0x00003FFF. Required: first three dropped; warm=1 after the third; outputs 1, 0, 0.
- Saturation: feed 0x7FFFFFFF then 0x80000000. Required: outputs 32767 then -32768; sat_flag=1 after the first; clr_flags pulse clears it.
- Decimation (DECIM=4, WARMUP=0): feed k<<15 for k=0..11 on consecutive cycles. Required: exactly outputs 0, 4, 8.
- Back-pressure (out_ready=0): push 10 kept samples 1..10. Required: fifo_level saturates at 8; ovf_flag=1; after out_ready=1, output is 1..8 in order, then out_valid=0.
- Full plus simultaneous pop: with level=8 and out_ready=1, push continuously. Required: level stays 8, ovf_flag stays 0, order preserved.
- Reset mid-stream: assert reset with level=5 and warm=1. Required: immediately out_valid=0, fifo_level=0, warm=0, flags=0; after release the next 3 samples are dropped again.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants for the FIR output path.
// Holds the FIR geometry, a helper that derives the start-up transient length,
// helpers for the signed saturation limits, and the warm-up state type.
package fir_pkg;

    localparam int FIR_IN_W     = 32;
    localparam int FIR_OUT_W    = 16;
    localparam int FIR_TAPS     = 321;
    localparam int FIR_PIPE_LAT = 5;

    // Number of samples the FIR emits before its delay line is fully populated
    function automatic int fir_warmup(input int taps, input int pipe_lat);
        return taps + pipe_lat;
    endfunction

    // Signed saturation limits for an out_w-bit result
    function automatic longint fir_sat_max(input int out_w);
        return (longint'(1) <<< (out_w - 1)) - 1;
    endfunction

    function automatic longint fir_sat_min(input int out_w);
        return -(longint'(1) <<< (out_w - 1));
    endfunction

    localparam int     FIR_WARMUP  = fir_warmup(FIR_TAPS, FIR_PIPE_LAT);
    localparam longint FIR_SAT_MAX = fir_sat_max(FIR_OUT_W);
    localparam longint FIR_SAT_MIN = fir_sat_min(FIR_OUT_W);

    typedef enum logic {
        WARMING = 1'b0,
        RUNNING = 1'b1
    } warm_state_e;

endpackage

// File: rtl/fir_out_requant_if.sv
// Valid/ready output stream of the requantiser.
//   out_valid : head of the output FIFO is valid
//   out_ready : consumer accepts out_data this cycle
//   out_data  : signed FIFO head, first-word fall-through
// master = producer (requantiser), slave = consumer.
interface fir_out_requant_if
    import fir_pkg::*;
#(
    parameter int OUT_W = FIR_OUT_W
);
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/fir_out_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, reset : clock, asynchronous active-high reset (pointers/level/head)
//   push/wdata : write request; ignored when full unless a pop happens too
//   pop        : read request; ignored when empty
//   rdata      : registered head; holds its last value while empty
//   full/empty/level : occupancy status
module fir_out_fifo
    import fir_pkg::*;
#(
    parameter int W     = FIR_OUT_W,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_nx;
    logic [W-1:0]  head;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_nx   = rd_ptr + 1'b1;
    assign rdata   = head;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // The head is a register so it can reset to zero and hold after the last pop.
    // Every push also lands in mem, so rd_ptr always tracks the head's slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            head   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_nx;
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (pop_ok) begin
                if (level > LW'(1)) begin
                    head <= mem[rd_nx];
                end else if (push_ok) begin
                    head <= wdata;
                end
            end else if (push_ok && empty) begin
                head <= wdata;
            end
        end
    end
endmodule

// File: rtl/fir_out_requant.sv
// FIR output requantiser: drops the FIR start-up transient, decimates,
// rounds/saturates to OUT_W bits and buffers the result in a FWFT FIFO.
//   clk, reset  : clock, asynchronous active-high reset
//   in_valid    : in_data carries a FIR sample this cycle (never back-pressured)
//   in_data     : signed full-precision FIR accumulator
//   clr_flags   : synchronous clear of sat_flag/ovf_flag (a coinciding set wins)
//   out         : valid/ready output stream (master side)
//   fifo_level  : FIFO occupancy
//   warm        : warm-up complete
//   sat_flag    : sticky, a kept sample was clipped
//   ovf_flag    : sticky, a kept sample was dropped on a full FIFO
module fir_out_requant
    import fir_pkg::*;
#(
    parameter int IN_W   = FIR_IN_W,
    parameter int OUT_W  = FIR_OUT_W,
    parameter int SHIFT  = 15,
    parameter int DECIM  = 4,
    parameter int WARMUP = fir_warmup(FIR_TAPS, FIR_PIPE_LAT),
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic signed [IN_W-1:0]   in_data,
    input  logic                     clr_flags,
    fir_out_requant_if.master        out,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     warm,
    output logic                     sat_flag,
    output logic                     ovf_flag
);
    localparam int WCW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
    localparam int PW  = (DECIM < 2) ? 1 : $clog2(DECIM);

    localparam logic signed [IN_W:0] RND    = (IN_W + 1)'(longint'(1) <<< (SHIFT - 1));
    localparam logic signed [IN_W:0] SAT_HI = (IN_W + 1)'(fir_sat_max(OUT_W));
    localparam logic signed [IN_W:0] SAT_LO = (IN_W + 1)'(fir_sat_min(OUT_W));

    warm_state_e             state, state_nx;
    logic [WCW-1:0]          wcnt, wcnt_nx;
    logic [PW-1:0]           phase;
    logic                    run;
    logic                    keep;

    logic signed [IN_W:0]    ext;
    logic signed [IN_W:0]    r;
    logic                    clip_hi;
    logic                    clip_lo;
    logic signed [OUT_W-1:0] sat_val;
    logic signed [OUT_W-1:0] q;
    logic                    q_valid;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop;
    logic                    drop;
    logic [OUT_W-1:0]        fifo_rdata;

    // Warm-up state register and counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WARMING;
            wcnt  <= '0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        case (state)
            WARMING: begin
                if (WARMUP == 0) begin
                    state_nx = RUNNING;
                end else if (in_valid) begin
                    wcnt_nx = wcnt + 1'b1;
                    if (wcnt == WCW'(WARMUP - 1)) begin
                        state_nx = RUNNING;
                    end
                end
            end
            RUNNING: begin
                state_nx = RUNNING;
            end
            default: begin
                state_nx = WARMING;
            end
        endcase
    end

    assign warm = (state == RUNNING);
    // With no transient to discard, samples are usable before warm registers high.
    assign run  = warm || (WARMUP == 0);
    assign keep = in_valid && run && (phase == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= '0;
        end else if (in_valid && run) begin
            phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + 1'b1;
        end
    end

    // Round half toward +inf, then clip; one guard bit keeps the add from wrapping.
    assign ext     = {in_data[IN_W-1], in_data} + RND;
    assign r       = ext >>> SHIFT;
    assign clip_hi = (r > SAT_HI);
    assign clip_lo = (r < SAT_LO);

    always_comb begin
        sat_val = r[OUT_W-1:0];
        if (clip_hi) begin
            sat_val = OUT_W'(SAT_HI);
        end else if (clip_lo) begin
            sat_val = OUT_W'(SAT_LO);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            q_valid <= keep;
            if (keep) begin
                q <= sat_val;
            end
        end
    end

    assign pop  = out.out_valid && out.out_ready;
    assign drop = q_valid && fifo_full && !pop;

    fir_out_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (q_valid),
        .wdata (q),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign out.out_valid = !fifo_empty;
    assign out.out_data  = fifo_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            if (keep && (clip_hi || clip_lo)) begin
                sat_flag <= 1'b1;
            end else if (clr_flags) begin
                sat_flag <= 1'b0;
            end
            if (drop) begin
                ovf_flag <= 1'b1;
            end else if (clr_flags) begin
                ovf_flag <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fir_out_requant.sv
// Testbench for fir_out_requant.
// dut_a: WARMUP=3, DECIM=1 (warm-up, rounding, saturation, FIFO behaviour, reset).
// dut_b: WARMUP=0, DECIM=4 (decimation).
// Expected output samples are queued when stimulus is driven and checked
// when the DUT hands them over on out_valid && out_ready.
module tb_fir_out_requant;
    import fir_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int b_outs   = 0;

    logic signed [15:0] sb_a[$];
    logic signed [15:0] sb_b[$];

    // DUT A
    logic               a_in_valid;
    logic signed [31:0] a_in_data;
    logic               a_clr;
    logic [3:0]         a_level;
    logic               a_warm, a_sat, a_ovf;
    fir_out_requant_if #(.OUT_W(16)) a_if ();

    fir_out_requant #(
        .IN_W(32), .OUT_W(16), .SHIFT(15), .DECIM(1), .WARMUP(3), .DEPTH(8)
    ) dut_a (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (a_in_valid),
        .in_data    (a_in_data),
        .clr_flags  (a_clr),
        .out        (a_if.master),
        .fifo_level (a_level),
        .warm       (a_warm),
        .sat_flag   (a_sat),
        .ovf_flag   (a_ovf)
    );

    // DUT B
    logic               b_in_valid;
    logic signed [31:0] b_in_data;
    logic               b_clr;
    logic [3:0]         b_level;
    logic               b_warm, b_sat, b_ovf;
    fir_out_requant_if #(.OUT_W(16)) b_if ();

    fir_out_requant #(
        .IN_W(32), .OUT_W(16), .SHIFT(15), .DECIM(4), .WARMUP(0), .DEPTH(8)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (b_in_valid),
        .in_data    (b_in_data),
        .clr_flags  (b_clr),
        .out        (b_if.master),
        .fifo_level (b_level),
        .warm       (b_warm),
        .sat_flag   (b_sat),
        .ovf_flag   (b_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Output monitors: a transfer sampled here completes on the next rising edge
    always @(negedge clk) begin
        logic signed [15:0] e;
        if (!reset && a_if.out_valid && a_if.out_ready) begin
            n_assert++;
            assert (sb_a.size() > 0) else begin
                n_fail++;
                $error("FAIL a_unexpected: observed out_data %0d expected no output", a_if.out_data);
            end
            if (sb_a.size() > 0) begin
                e = sb_a.pop_front();
                n_assert++;
                assert (a_if.out_data === e) else begin
                    n_fail++;
                    $error("FAIL a_out_data: observed %0d expected %0d", a_if.out_data, e);
                end
            end
        end
        if (!reset && b_if.out_valid && b_if.out_ready) begin
            b_outs++;
            n_assert++;
            assert (sb_b.size() > 0) else begin
                n_fail++;
                $error("FAIL b_unexpected: observed out_data %0d expected no output", b_if.out_data);
            end
            if (sb_b.size() > 0) begin
                e = sb_b.pop_front();
                n_assert++;
                assert (b_if.out_data === e) else begin
                    n_fail++;
                    $error("FAIL b_out_data: observed %0d expected %0d", b_if.out_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_send(input logic [31:0] x);
        a_in_valid = 1'b1;
        a_in_data  = x;
        tick();
        a_in_valid = 1'b0;
        a_in_data  = '0;
    endtask

    task automatic b_send(input logic [31:0] x);
        b_in_valid = 1'b1;
        b_in_data  = x;
        tick();
        b_in_valid = 1'b0;
        b_in_data  = '0;
    endtask

    task automatic drain_a(input string tag);
        int i = 0;
        while ((sb_a.size() != 0 || a_if.out_valid) && i < 50) begin
            tick();
            i++;
        end
        chk(tag, 32'((sb_a.size() == 0) && !a_if.out_valid), 32'd1);
    endtask

    task automatic drain_b(input string tag);
        int i = 0;
        while ((sb_b.size() != 0 || b_if.out_valid) && i < 50) begin
            tick();
            i++;
        end
        chk(tag, 32'((sb_b.size() == 0) && !b_if.out_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_clr = 1'b0; a_if.out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_clr = 1'b0; b_if.out_ready = 1'b0;
        #2;
        chk("rst_out_valid", 32'(a_if.out_valid), 32'd0);
        chk("rst_out_data",  32'(a_if.out_data), 32'd0);
        chk("rst_level",     32'(a_level), 32'd0);
        chk("rst_warm",      32'(a_warm), 32'd0);
        chk("rst_sat",       32'(a_sat), 32'd0);
        chk("rst_ovf",       32'(a_ovf), 32'd0);
        tick();
        reset = 1'b0;

        // Decimation on dut_b: keep k = 0, 4, 8
        b_if.out_ready = 1'b1;
        tick();
        tick();
        chk("b_warm_after_reset", 32'(b_warm), 32'd1);
        for (int k = 0; k < 12; k++) begin
            if (k % 4 == 0) sb_b.push_back(16'(k));
            b_send(32'(k) << 15);
        end
        drain_b("b_drain");
        chk("b_output_count", 32'(b_outs), 32'd3);

        // Warm-up and rounding
        a_if.out_ready = 1'b1;
        a_send(32'h0000_0001);
        a_send(32'h0000_0002);
        chk("warm_after_2", 32'(a_warm), 32'd0);
        a_send(32'h0000_0003);
        chk("warm_after_3", 32'(a_warm), 32'd1);
        sb_a.push_back(16'sd1);  a_send(32'h0000_4000);
        sb_a.push_back(16'sd0);  a_send(32'hFFFF_C000);
        sb_a.push_back(16'sd0);  a_send(32'h0000_3FFF);
        drain_a("round_drain");
        chk("round_no_sat", 32'(a_sat), 32'd0);

        // Saturation and flag clear
        sb_a.push_back(16'sd32767);
        a_send(32'h7FFF_FFFF);
        chk("sat_set", 32'(a_sat), 32'd1);
        sb_a.push_back(-16'sd32768);
        a_send(32'h8000_0000);
        drain_a("sat_drain");
        chk("sat_sticky", 32'(a_sat), 32'd1);
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        chk("sat_cleared", 32'(a_sat), 32'd0);

        // Back-pressure and overflow
        a_if.out_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k <= 8) sb_a.push_back(16'(k));
            a_send(32'(k) << 15);
        end
        tick();
        tick();
        chk("bp_level_full", 32'(a_level), 32'd8);
        chk("bp_ovf", 32'(a_ovf), 32'd1);
        chk("bp_head_stable", 32'(a_if.out_data), 32'd1);
        a_if.out_ready = 1'b1;
        drain_a("bp_drain");
        chk("bp_level_empty", 32'(a_level), 32'd0);
        chk("empty_holds_data", 32'(a_if.out_data), 32'd8);
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        chk("ovf_cleared", 32'(a_ovf), 32'd0);

        // Full FIFO with simultaneous push and pop
        a_if.out_ready = 1'b0;
        for (int k = 11; k <= 18; k++) begin
            sb_a.push_back(16'(k));
            a_send(32'(k) << 15);
        end
        tick();
        chk("fp_level_full", 32'(a_level), 32'd8);
        sb_a.push_back(16'sd19);
        a_send(32'd19 << 15);
        a_if.out_ready = 1'b1;
        for (int k = 20; k <= 38; k++) begin
            sb_a.push_back(16'(k));
            a_send(32'(k) << 15);
            chk($sformatf("fp_level_%0d", k), 32'(a_level), 32'd8);
        end
        chk("fp_no_ovf", 32'(a_ovf), 32'd0);
        drain_a("fp_drain");
        chk("fp_no_ovf_end", 32'(a_ovf), 32'd0);

        // Reset mid-stream
        a_if.out_ready = 1'b0;
        a_send(32'h7FFF_FFFF);
        for (int k = 1; k <= 4; k++) a_send(32'(k) << 15);
        tick();
        chk("mid_level", 32'(a_level), 32'd5);
        chk("mid_warm", 32'(a_warm), 32'd1);
        chk("mid_sat", 32'(a_sat), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mrst_out_valid", 32'(a_if.out_valid), 32'd0);
        chk("mrst_level", 32'(a_level), 32'd0);
        chk("mrst_warm", 32'(a_warm), 32'd0);
        chk("mrst_sat", 32'(a_sat), 32'd0);
        chk("mrst_ovf", 32'(a_ovf), 32'd0);
        chk("mrst_out_data", 32'(a_if.out_data), 32'd0);
        tick();
        reset = 1'b0;
        a_if.out_ready = 1'b1;
        a_send(32'd5 << 15);
        a_send(32'd5 << 15);
        chk("rewarm_after_2", 32'(a_warm), 32'd0);
        a_send(32'd5 << 15);
        chk("rewarm_after_3", 32'(a_warm), 32'd1);
        sb_a.push_back(16'sd7);
        a_send(32'd7 << 15);
        drain_a("rewarm_drain");
        chk("rewarm_level", 32'(a_level), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
